// File: rtl/emu_pkg.sv
// Shared definitions for the co-emulation transactor.
//   step_state_t : step controller states
//   STEP_OFS/STAT_OFS : register offsets below 2^ADDR_W
//   ST_* : bit positions inside the status byte
package emu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2
  } step_state_t;

  localparam int unsigned STEP_OFS = 3;
  localparam int unsigned STAT_OFS = 2;

  localparam int unsigned ST_RUN_DONE = 0;
  localparam int unsigned ST_BUSY     = 1;
  localparam int unsigned ST_IO_PEND  = 2;
  localparam int unsigned ST_ERR      = 3;

endpackage

// File: rtl/emu_step_fsm.sv
// Step controller: runs the DUT for a programmed number of clock enables,
// stopping early when the DUT raises io_req after an enabled cycle.
//   step_wr/step_data : host write to the step register
//   io_req            : DUT I/O request
//   dut_clk_en        : one-cycle DUT clock enable
//   busy              : run (including capture cycle) in progress
//   capt_now          : capture DUT outputs this cycle
//   io_stop           : run is being terminated by io_req
module emu_step_fsm
  import emu_pkg::*;
(
  input  logic       clk_emu,
  input  logic       reset,
  input  logic       step_wr,
  input  logic [7:0] step_data,
  input  logic       io_req,
  output logic       dut_clk_en,
  output logic       busy,
  output logic       capt_now,
  output logic       io_stop
);

  step_state_t state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        en_q;

  always_ff @(posedge clk_emu) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      en_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      en_q  <= dut_clk_en;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (step_wr && (step_data != 8'd0)) begin
          cnt_nxt   = step_data;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // io_req only counts once the DUT has actually been clocked
        if (io_req && en_q) begin
          state_nxt = CAPT;
        end else begin
          cnt_nxt = cnt - 8'd1;
          if (cnt == 8'd1) state_nxt = CAPT;
        end
      end
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dut_clk_en = 1'b0;
    busy       = 1'b0;
    capt_now   = 1'b0;
    io_stop    = 1'b0;
    case (state)
      RUN: begin
        busy = 1'b1;
        if (io_req && en_q) io_stop = 1'b1;
        // reset kills the enable in the same cycle it is applied
        else                dut_clk_en = !reset;
      end
      CAPT: begin
        busy     = 1'b1;
        capt_now = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/emu_transactor.sv
// Co-emulation transactor: host byte register map, double-buffered stimulus,
// capture bytes and status, with a step controller driving the DUT enable.
//   host_addr/host_wdata/host_wr/host_rdata : host register access
//   load_emu : copy stimulus shadow to stim_vec
//   get_emu  : snapshot capt_vec into capture bytes
//   stim_vec/capt_vec : DUT stimulus / live DUT outputs
//   io_req, dut_clk_en, busy, io_pending : step control and status
module emu_transactor
  import emu_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_OUT  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                 clk_emu,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    host_addr,
  input  logic [7:0]           host_wdata,
  input  logic                 host_wr,
  output logic [7:0]           host_rdata,
  input  logic                 load_emu,
  input  logic                 get_emu,
  output logic [8*N_IN-1:0]    stim_vec,
  input  logic [8*N_OUT-1:0]   capt_vec,
  input  logic                 io_req,
  output logic                 dut_clk_en,
  output logic                 busy,
  output logic                 io_pending
);

  localparam logic [ADDR_W-1:0] STEP_ADDR = ADDR_W'((1 << ADDR_W) - STEP_OFS);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'((1 << ADDR_W) - STAT_OFS);

  logic [8*N_IN-1:0]  shadow_q;
  logic [8*N_OUT-1:0] capt_q;
  logic               err_q, run_done_q;
  logic               step_wr, stat_wr;
  logic               capt_now, io_stop;
  logic [7:0]         stat_byte, rd_next;

  assign step_wr = host_wr && (host_addr == STEP_ADDR);
  assign stat_wr = host_wr && (host_addr == STAT_ADDR);

  emu_step_fsm u_step (
    .clk_emu    (clk_emu),
    .reset      (reset),
    .step_wr    (step_wr),
    .step_data  (host_wdata),
    .io_req     (io_req),
    .dut_clk_en (dut_clk_en),
    .busy       (busy),
    .capt_now   (capt_now),
    .io_stop    (io_stop)
  );

  always_comb begin
    stat_byte              = '0;
    stat_byte[ST_RUN_DONE] = run_done_q;
    stat_byte[ST_BUSY]     = busy;
    stat_byte[ST_IO_PEND]  = io_pending;
    stat_byte[ST_ERR]      = err_q;
  end

  always_comb begin
    rd_next = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (host_addr == ADDR_W'(k)) rd_next = capt_q[8*k +: 8];
    end
    if (host_addr == STAT_ADDR) rd_next = stat_byte;
  end

  always_ff @(posedge clk_emu) begin
    if (reset) begin
      shadow_q   <= '0;
      stim_vec   <= '0;
      capt_q     <= '0;
      err_q      <= 1'b0;
      run_done_q <= 1'b0;
      io_pending <= 1'b0;
      host_rdata <= '0;
    end else begin
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (host_wr && (host_addr == ADDR_W'(k))) shadow_q[8*k +: 8] <= host_wdata;
      end
      // stim_vec takes the pre-write shadow when a write and load coincide
      if (load_emu && !busy) stim_vec <= shadow_q;
      if ((get_emu && !busy) || capt_now) capt_q <= capt_vec;

      // clears first so a same-cycle set event is not lost
      if (stat_wr) begin
        err_q      <= 1'b0;
        run_done_q <= 1'b0;
        io_pending <= 1'b0;
      end
      if (capt_now) run_done_q <= 1'b1;
      if (io_stop)  io_pending <= 1'b1;
      if (busy && (load_emu || step_wr)) err_q <= 1'b1;

      host_rdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_emu_transactor.sv
module tb_emu_transactor;

  localparam int unsigned N_IN   = 4;
  localparam int unsigned N_OUT  = 4;
  localparam int unsigned ADDR_W = 8;
  localparam logic [7:0] STEP_A = 8'd253;
  localparam logic [7:0] STAT_A = 8'd254;

  logic        clk_emu = 1'b0;
  logic        reset;
  logic [7:0]  host_addr, host_wdata, host_rdata;
  logic        host_wr, load_emu, get_emu, io_req;
  logic [31:0] stim_vec, capt_vec;
  logic        dut_clk_en, busy, io_pending;

  int unsigned checks = 0;
  int unsigned failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk_emu = ~clk_emu;

  emu_transactor #(.N_IN(N_IN), .N_OUT(N_OUT), .ADDR_W(ADDR_W)) dut (
    .clk_emu    (clk_emu),
    .reset      (reset),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_wr    (host_wr),
    .host_rdata (host_rdata),
    .load_emu   (load_emu),
    .get_emu    (get_emu),
    .stim_vec   (stim_vec),
    .capt_vec   (capt_vec),
    .io_req     (io_req),
    .dut_clk_en (dut_clk_en),
    .busy       (busy),
    .io_pending (io_pending)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop_chk(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      chk_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk_eq(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(negedge clk_emu);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_addr  = a;
    host_wdata = d;
    host_wr    = 1'b1;
    tick();
    host_wr    = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    sb_push(tag, {24'd0, exp});
    host_addr = a;
    tick();
    sb_pop_chk({24'd0, host_rdata});
  endtask

  // Counts enables and busy cycles until busy falls; optionally raises
  // io_req just after the edge that follows enable number stop_after.
  task automatic run_steps(input int unsigned stop_after,
                           output int unsigned n_en, output int unsigned n_busy);
    bit done;
    n_en = 0;
    n_busy = 0;
    done = 1'b0;
    for (int unsigned c = 0; c < 300; c++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      n_busy++;
      if (dut_clk_en) n_en++;
      if (stop_after != 0 && n_en == stop_after && !io_req) begin
        @(posedge clk_emu);
        #1 io_req = 1'b1;
      end
      tick();
    end
    io_req = 1'b0;
    if (!done) chk_eq("run_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int unsigned n_en, n_busy, n0;
    reset = 1'b1; host_addr = '0; host_wdata = '0; host_wr = 1'b0;
    load_emu = 1'b0; get_emu = 1'b0; io_req = 1'b0; capt_vec = 32'hA5C3_0F96;
    repeat (3) tick();
    chk_eq("rst_rdata", {24'd0, host_rdata}, 32'h0);
    chk_eq("rst_en", {31'd0, dut_clk_en}, 32'd0);
    chk_eq("rst_busy", {31'd0, busy}, 32'd0);
    chk_eq("rst_stim", stim_vec, 32'h0);
    reset = 1'b0;
    tick();
    host_read(STAT_A, 8'h00, "rst_stat");
    host_read(8'd0, 8'h00, "rst_capt0");
    host_read(8'd100, 8'h00, "unmapped_rd");
    host_read(STEP_A, 8'h00, "step_rd");

    // stimulus double buffering
    host_write(8'd0, 8'h11);
    host_write(8'd1, 8'h22);
    host_write(8'd2, 8'h33);
    host_write(8'd3, 8'h44);
    sb_push("stim_load", 32'h4433_2211);
    load_emu = 1'b1; tick(); load_emu = 1'b0;
    sb_pop_chk(stim_vec);
    host_write(8'd0, 8'h55);
    tick();
    chk_eq("stim_noload", stim_vec, 32'h4433_2211);

    // zero step count is a no-op
    host_write(STEP_A, 8'd0);
    chk_eq("step0_busy", {31'd0, busy}, 32'd0);

    // plain 5-step run
    sb_push("run5_en", 32'd5);
    sb_push("run5_busy", 32'd6);
    host_write(STEP_A, 8'd5);
    run_steps(0, n_en, n_busy);
    sb_pop_chk(n_en);
    sb_pop_chk(n_busy);
    host_read(STAT_A, 8'h01, "run5_stat");
    host_read(8'd0, 8'h96, "run5_c0");
    host_read(8'd1, 8'h0F, "run5_c1");
    host_read(8'd2, 8'hC3, "run5_c2");
    host_read(8'd3, 8'hA5, "run5_c3");
    host_read(8'd4, 8'h00, "capt_oob");

    // get_emu snapshot while idle
    capt_vec = 32'h1357_9BDF;
    get_emu = 1'b1; tick(); get_emu = 1'b0;
    host_read(8'd2, 8'h57, "get_c2");

    // run stopped by io_req after 3rd enable
    capt_vec = 32'hCAFE_F00D;
    sb_push("io_en", 32'd3);
    sb_push("io_busy", 32'd5);
    host_write(STEP_A, 8'd10);
    run_steps(3, n_en, n_busy);
    sb_pop_chk(n_en);
    sb_pop_chk(n_busy);
    chk_eq("io_pending", {31'd0, io_pending}, 32'd1);
    host_read(STAT_A, 8'h05, "io_stat");
    host_read(8'd3, 8'hCA, "io_c3");
    host_write(STAT_A, 8'h00);
    host_read(STAT_A, 8'h00, "stat_clr");

    // load and step writes while busy are rejected
    host_write(STEP_A, 8'd6);
    n0 = 0;
    load_emu = 1'b1;
    if (dut_clk_en) n0++;
    tick();
    load_emu = 1'b0;
    host_addr = STEP_A; host_wdata = 8'd1; host_wr = 1'b1;
    if (dut_clk_en) n0++;
    tick();
    host_wr = 1'b0;
    sb_push("err_run_en", 32'd6);
    run_steps(0, n_en, n_busy);
    sb_pop_chk(n_en + n0);
    chk_eq("err_stim", stim_vec, 32'h4433_2211);
    host_read(STAT_A, 8'h09, "err_stat");
    host_write(STAT_A, 8'h00);
    load_emu = 1'b1; tick(); load_emu = 1'b0;
    chk_eq("stim_late", stim_vec, 32'h4433_2255);

    // reset in the middle of an 8-step run
    host_write(STEP_A, 8'd8);
    n_en = 0;
    for (int unsigned c = 0; c < 20; c++) begin
      if (dut_clk_en) n_en++;
      if (n_en == 2) break;
      tick();
    end
    chk_eq("mid_en2", n_en, 32'd2);
    reset = 1'b1;
    tick();
    chk_eq("mid_en", {31'd0, dut_clk_en}, 32'd0);
    chk_eq("mid_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();
    chk_eq("mid_busy2", {31'd0, busy}, 32'd0);
    host_read(8'd0, 8'h00, "mid_c0");
    host_read(STAT_A, 8'h00, "mid_stat");
    chk_eq("mid_stim", stim_vec, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
